// File: rtl/control_sequencer.sv
// Instruction fetch/decode/execute sequencer for the 8-bit datapath.
// Optional build macro CU_SINGLE_STEP_EN adds a Step input that gates each fetch.
module control_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
`ifdef CU_SINGLE_STEP_EN
    input  logic        Step,
`endif
    input  logic [15:0] IRout,
    input  logic [3:0]  Flags,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_En,
    output logic [1:0]  IR_FunSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [2:0]  State
);

    localparam int OPW = 4;

    typedef enum logic [2:0] {
        S_FETCH_H = 3'd0,
        S_FETCH_L = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC1   = 3'd3,
        S_EXEC2   = 3'd4,
        S_HALT    = 3'd6,
        S_INIT    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op;
    logic [1:0]       dst, s1, s2, rsel;
    logic [3:0]       dst_en, reg_en;
    logic             step_go;
    logic             br_taken;

    assign op     = IRout[15:12];
    assign dst    = IRout[11:10];
    assign s1     = IRout[9:8];
    assign s2     = IRout[7:6];
    assign rsel   = IRout[9:8];
    assign dst_en = ~(4'b0001 << dst);
    assign reg_en = ~(4'b0001 << rsel);
    assign State  = state_q;

`ifdef CU_SINGLE_STEP_EN
    assign step_go = Step;
`else
    assign step_go = 1'b1;
`endif

    function automatic logic [3:0] alu_code(input logic [OPW-1:0] opc);
        case (opc)
            4'h0:    alu_code = 4'b0111;
            4'h1:    alu_code = 4'b1000;
            4'h2:    alu_code = 4'b0010;
            4'h3:    alu_code = 4'b0100;
            4'h4:    alu_code = 4'b0110;
            4'h5:    alu_code = 4'b1010;
            4'h6:    alu_code = 4'b1011;
            default: alu_code = 4'b0000;
        endcase
    endfunction

    always_comb begin
        case (op)
            4'hB:    br_taken = 1'b1;
            4'hC:    br_taken = ~Flags[0];
            4'hD:    br_taken = Flags[0];
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    state_d = S_FETCH_H;
            S_FETCH_H: state_d = step_go ? S_FETCH_L : S_FETCH_H;
            S_FETCH_L: state_d = S_DECODE;
            S_DECODE:  state_d = (op == 4'hF) ? S_HALT : S_EXEC1;
            S_EXEC1:   state_d = (op == 4'h7 || op == 4'h8 || op == 4'h9) ? S_EXEC2 : S_FETCH_H;
            S_EXEC2:   state_d = S_FETCH_H;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_INIT;
        endcase
    end

    always_comb begin
        RF_OutASel  = 2'd0;
        RF_OutBSel  = 2'd0;
        RF_FunSel   = 2'd2;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'd0;
        ARF_OutDSel = 2'd0;
        ARF_FunSel  = 2'd2;
        ARF_RegSel  = 4'b1111;
        IR_LH       = 1'b0;
        IR_En       = 1'b0;
        IR_FunSel   = 2'd2;
        MuxASel     = 2'd0;
        MuxBSel     = 2'd0;
        MuxCSel     = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        // Outputs stay idle while reset is held so an abandoned instruction commits nothing.
        if (RST_N) begin
            case (state_q)
                S_INIT: begin
                    RF_FunSel  = 2'd3;
                    RF_RegSel  = 4'b0000;
                    ARF_FunSel = 2'd3;
                    ARF_RegSel = 4'b1000;
                end
                S_FETCH_H, S_FETCH_L: begin
                    if (state_q == S_FETCH_L || step_go) begin
                        Mem_CS     = 1'b0;
                        IR_En      = 1'b1;
                        IR_LH      = (state_q == S_FETCH_L);
                        ARF_FunSel = 2'd1;
                        ARF_RegSel = 4'b1110;
                    end
                end
                S_EXEC1: begin
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            RF_OutASel = s1;
                            RF_OutBSel = s2;
                            ALU_FunSel = alu_code(op);
                            RF_RegSel  = dst_en;
                        end
                        4'h8, 4'h9: begin
                            MuxBSel    = 2'd2;
                            ARF_RegSel = 4'b1101;
                        end
                        4'hA: begin
                            MuxASel   = 2'd2;
                            RF_RegSel = reg_en;
                        end
                        4'hB, 4'hC, 4'hD: begin
                            MuxBSel    = 2'd2;
                            ARF_RegSel = br_taken ? 4'b1110 : 4'b1111;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    case (op)
                        4'h7: begin
                            RF_FunSel = 2'd1;
                            RF_RegSel = dst_en;
                        end
                        4'h8: begin
                            ARF_OutDSel = 2'd2;
                            Mem_CS      = 1'b0;
                            MuxASel     = 2'd1;
                            RF_RegSel   = reg_en;
                        end
                        4'h9: begin
                            RF_OutASel  = rsel;
                            ARF_OutDSel = 2'd2;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer.
module tb_control_sequencer;

    logic        CLK, RST_N;
    logic [15:0] IRout;
    logic [3:0]  Flags;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [1:0]  IR_FunSel, MuxASel, MuxBSel;
    logic [3:0]  RF_RegSel, ALU_FunSel, ARF_RegSel;
    logic        IR_LH, IR_En, MuxCSel, Mem_WR, Mem_CS;
    logic [2:0]  State;
`ifdef CU_SINGLE_STEP_EN
    logic        Step = 1'b1;
`endif

    control_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
`ifdef CU_SINGLE_STEP_EN
        .Step(Step),
`endif
        .IRout(IRout), .Flags(Flags),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_En(IR_En), .IR_FunSel(IR_FunSel), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .State(State)
    );

    typedef struct packed {
        logic [1:0] asel, bsel, rffun;
        logic [3:0] rfreg, alu;
        logic [1:0] csel, dsel, arffun;
        logic [3:0] arfreg;
        logic       lh, en;
        logic [1:0] irfun, ma, mb;
        logic       mc, wr, cs;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  fl;
        logic        two;
        outs_t       e1, e2;
    } vec_t;

    outs_t got;
    assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                  ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_En, IR_FunSel, MuxASel,
                  MuxBSel, MuxCSel, Mem_WR, Mem_CS};

    int checks = 0;
    int passed = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic outs_t o(input logic [1:0] asel, bsel, rffun, input logic [3:0] rfreg, alu,
                                input logic [1:0] dsel, arffun, input logic [3:0] arfreg,
                                input logic [1:0] ma, mb, input logic wr, cs, en, lh);
        outs_t r;
        r.asel = asel; r.bsel = bsel; r.rffun = rffun; r.rfreg = rfreg; r.alu = alu;
        r.csel = 2'd0; r.dsel = dsel; r.arffun = arffun; r.arfreg = arfreg;
        r.lh = lh; r.en = en; r.irfun = 2'd2; r.ma = ma; r.mb = mb; r.mc = 1'b0;
        r.wr = wr; r.cs = cs;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_o(input string nm, input outs_t exp);
        checks++;
        if (got !== exp) $display("FAIL %s: outputs got %h expected %h", nm, got, exp);
        else passed++;
    endtask

    task automatic chk_st(input string nm, input logic [2:0] exp);
        checks++;
        if (State !== exp) $display("FAIL %s: State got %0d expected %0d", nm, State, exp);
        else passed++;
    endtask

    outs_t IDLE, FH, FL, INIT_O, LDST1;
    vec_t  vt[14];

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d_%h", idx, v.ir);
        IRout = v.ir;
        Flags = v.fl;
        chk_st({tag, "_fh_st"}, 3'd0);
        chk_o({tag, "_fh"}, FH);
        tick();
        chk_st({tag, "_fl_st"}, 3'd1);
        chk_o({tag, "_fl"}, FL);
        tick();
        chk_st({tag, "_dec_st"}, 3'd2);
        chk_o({tag, "_dec"}, IDLE);
        tick();
        chk_st({tag, "_e1_st"}, 3'd3);
        chk_o({tag, "_e1"}, v.e1);
        if (v.two) begin
            tick();
            chk_st({tag, "_e2_st"}, 3'd4);
            chk_o({tag, "_e2"}, v.e2);
        end
        tick();
    endtask

    initial begin
        IDLE   = o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        FH     = o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd1, 4'hE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        FL     = o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd1, 4'hE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        INIT_O = o(2'd0, 2'd0, 2'd3, 4'h0, 4'h0, 2'd0, 2'd3, 4'h8, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        LDST1  = o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hD, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        // ALU ops: ADD R1<-R2+R3, AND R4<-R3&R2, NOT R2<-~R1, LSR R3<-R4>>1
        vt[0]  = '{16'h3180, 4'h0, 1'b0,
                   o(2'd1, 2'd2, 2'd2, 4'hE, 4'b0100, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[1]  = '{16'h0E40, 4'h0, 1'b0,
                   o(2'd2, 2'd1, 2'd2, 4'h7, 4'b0111, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[2]  = '{16'h2400, 4'h0, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hD, 4'b0010, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[3]  = '{16'h6B00, 4'h0, 1'b0,
                   o(2'd3, 2'd0, 2'd2, 4'hB, 4'b1011, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        // INC R4<-R2+1: copy then increment
        vt[4]  = '{16'h7D00, 4'h0, 1'b1,
                   o(2'd1, 2'd0, 2'd2, 4'h7, 4'b0000, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0),
                   o(2'd0, 2'd0, 2'd1, 4'h7, 4'b0000, 2'd0, 2'd2, 4'hF, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
        vt[5]  = '{16'h8240, 4'h0, 1'b1, LDST1,
                   o(2'd0, 2'd0, 2'd2, 4'hB, 4'b0000, 2'd2, 2'd2, 4'hF, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vt[6]  = '{16'h9140, 4'h0, 1'b1, LDST1,
                   o(2'd1, 2'd0, 2'd2, 4'hF, 4'b0000, 2'd2, 2'd2, 4'hF, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
        vt[7]  = '{16'hA35A, 4'h0, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'h7, 4'b0000, 2'd0, 2'd2, 4'hF, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        // Branches: taken enables PC, not-taken keeps PC disabled
        vt[8]  = '{16'hB020, 4'h0, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hE, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[9]  = '{16'hC010, 4'b0000, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hE, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[10] = '{16'hC010, 4'b0001, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hF, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[11] = '{16'hD010, 4'b0001, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hE, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[12] = '{16'hD010, 4'b1110, 1'b0,
                   o(2'd0, 2'd0, 2'd2, 4'hF, 4'h0, 2'd0, 2'd2, 4'hF, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0), IDLE};
        vt[13] = '{16'hE000, 4'h0, 1'b0, IDLE, IDLE};

        RST_N = 1'b0;
        IRout = 16'h0000;
        Flags = 4'h0;
        tick();
        tick();
        chk_st("rst_held", 3'd7);
        RST_N = 1'b1;
        #1;
        chk_o("init_outputs", INIT_O);
        tick();

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Halt holds idle until reset
        IRout = 16'hF000;
        chk_st("hlt_fh", 3'd0);
        tick();
        tick();
        chk_st("hlt_dec", 3'd2);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk_st($sformatf("halt_st%0d", i), 3'd6);
            chk_o($sformatf("halt_idle%0d", i), IDLE);
            tick();
        end
        RST_N = 1'b0;
        tick();
        chk_st("halt_rst", 3'd7);
        RST_N = 1'b1;
        tick();
        chk_st("halt_recover", 3'd0);

        // Reset during EXEC1 of a load abandons it before EXEC2
        IRout = 16'h8240;
        tick();
        tick();
        tick();
        chk_st("ld_e1", 3'd3);
        RST_N = 1'b0;
        #1;
        chk_o("ld_rst_idle", IDLE);
        tick();
        chk_st("ld_rst_init", 3'd7);
        RST_N = 1'b1;
        #1;
        chk_o("ld_rst_init_out", INIT_O);
        tick();
        chk_st("ld_rst_fetch", 3'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
